l2_cache: RTL and testbench
===========================

# l2_cache

Direct-mapped, write-back second-level cache downstream of the L1 cache arbiter. It accepts one 256-bit-line request at a time from whichever L1 the arbiter has selected, and serves hits from local storage. Misses go to physical memory: a dirty-victim writeback first if needed, then a line fill. Completion is signalled with a one-cycle `mem_resp` pulse, which drives the arbiter's response input.

## Interface
Reset is synchronous and active-high, on `rst`. The block has one clock, `clk`.

Parameters:
- `S_INDEX`, default 3: index bits; the cache has 2^S_INDEX sets.
- `S_OFFSET`, default 5: line offset bits, giving 32-byte lines.
- `S_TAG`, default 32 - S_INDEX - S_OFFSET: tag bits (24 at default).

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous active-high reset.
- `mem_read`, in, 1: upstream read request, held until `mem_resp`.
- `mem_write`, in, 1: upstream write request, held until `mem_resp`.
- `mem_address`, in, 32: upstream line address; bits [S_OFFSET-1:0] are ignored.
- `mem_wdata256`, in, 256: upstream write line.
- `mem_byte_enable256`, in, 32: per-byte write enable.
- `mem_rdata256`, out, 256: read line, valid while `mem_resp` = 1.
- `mem_resp`, out, 1: one-cycle completion pulse.
- `pmem_read`, out, 1: memory fill request.
- `pmem_write`, out, 1: memory writeback request.
- `pmem_address`, out, 32: line-aligned memory address.
- `pmem_wdata256`, out, 256: writeback line.
- `pmem_rdata256`, in, 256: fill line, valid with `pmem_resp`.
- `pmem_resp`, in, 1: memory completion.

## Operation
- Per-set state: `valid`, `dirty`, `tag`, 256-bit `data`. Reset clears all `valid` and `dirty` bits. `tag` and `data` are not reset.
- FSM states are IDLE, CHECK, WRITEBACK, ALLOCATE and DONE. Reset state is IDLE.
- **IDLE:** on `mem_read | mem_write`, latch the address, wdata, byte enables and operation, then go to CHECK.
  - If `mem_read` and `mem_write` are both 1, the operation is a write.
- **CHECK:** compare the latched tag against the stored tag for the latched index.
  - Read hit: go to DONE.
  - Write hit: merge enabled bytes into `data` at the clock edge, set `dirty`, go to DONE.
  - Miss with the victim `valid & dirty`: go to WRITEBACK.
  - Any other miss: go to ALLOCATE.
- **WRITEBACK:**
  - `pmem_write` = 1.
  - `pmem_address` = {stored tag, index, 0}.
  - `pmem_wdata256` = stored data.
  - Hold until `pmem_resp`, then go to ALLOCATE.
- **ALLOCATE:**
  - `pmem_read` = 1.
  - `pmem_address` = {latched tag, index, 0}.
  - On `pmem_resp`: load `data` from `pmem_rdata256`, set `tag`, set `valid` = 1 and `dirty` = 0, then return to CHECK. The second pass always hits.
- **DONE:** `mem_resp` = 1 and `mem_rdata256` = data[index]; then go to IDLE unconditionally.
- Once the FSM leaves IDLE, the transaction runs to DONE even if the upstream request drops. Upstream inputs are ignored outside IDLE.
- `pmem_read` and `pmem_write` are never both 1.

## Timing
- All outputs are 0 in reset and in IDLE.
- Hit latency: request seen in IDLE at cycle t, `mem_resp` = 1 in cycle t+2.
- Clean miss: `pmem_read` rises at t+2. `mem_resp` comes 2 cycles after the cycle in which `pmem_resp` = 1 (ALLOCATE, then CHECK, then DONE).
- Dirty miss: `pmem_write` rises at t+2. `pmem_read` rises the cycle after the `pmem_resp` for the writeback.
- `mem_resp` is exactly one cycle wide, and the FSM is back in IDLE the next cycle. This gives the arbiter's post-response cycle. A request present in that cycle is accepted as new.
- Reset mid-operation (any state): the next cycle, all outputs are 0 and the FSM is in IDLE. An in-flight pmem transaction is abandoned, and a late `pmem_resp` in IDLE is ignored. All lines become invalid, including one that was mid-fill.
- Index and tag select on the latched address only, never the live input.

## Structure
- Package `l2_types` holds:
  - the state enum;
  - `S_INDEX`, `S_OFFSET` and `S_TAG` defaults;
  - the `line_t` type (logic [255:0]);
  - the `be_t` type (logic [31:0]);
  - a byte-merge function.
- Sub-module `l2_line_array` holds the per-set storage: flip-flop arrays for valid, dirty, tag and data. It has an asynchronous read port, and one write port with load enables for each field. The FSM and the latch registers live in `l2_cache`.

## Test plan
Default parameters. Address 0x00001040 maps to index 2, tag 0x000010; address 0x00002040 maps to index 2, tag 0x000020. pmem latency is 5 cycles.

- **Cold read:** after reset, read 0x00001040.
  - Required: `pmem_read` with `pmem_address` = 0x00001040, fill line A, then `mem_rdata256` = A with a one-cycle `mem_resp`.
  - `pmem_write` is never asserted.
- **Read hit:** read 0x00001040 again.
  - Required: `mem_resp` at t+2, data = A, `pmem_read` stays 0.
- **Write hit:** write 0x00001040 with `mem_byte_enable256` = 0x0000000F and wdata[31:0] = 0xDEADBEEF.
  - Required: `mem_resp` at t+2.
  - A subsequent read returns A with [31:0] = 0xDEADBEEF and the other bytes unchanged.
- **Dirty eviction:** read 0x00002040.
  - Required: first `pmem_write` to 0x00001040 carrying the modified line; after its `pmem_resp`, `pmem_read` to 0x00002040; then `mem_resp` with fill line B.
- **Reset during ALLOCATE:** assert `rst` for 1 cycle during ALLOCATE.
  - Required: `pmem_read` = 0 and `mem_resp` = 0 the next cycle.
  - A re-read of 0x00002040 misses and issues `pmem_read` with no `pmem_write`.
- **Simultaneous read and write:** `mem_read` = `mem_write` = 1 on a hit.
  - Required: handled as a write; `dirty` is set, so a later eviction of that set issues `pmem_write`.

Source files
------------

// File: rtl/l2_types.sv
// Shared types, default geometry and byte-merge helper
// for the direct-mapped write-back L2 cache.
package l2_types;

  localparam int DEF_S_INDEX  = 3;
  localparam int DEF_S_OFFSET = 5;
  localparam int DEF_S_TAG    =
    32 - DEF_S_INDEX - DEF_S_OFFSET;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WRITEBACK,
    ST_ALLOCATE,
    ST_DONE
  } state_e;

  typedef logic [255:0] line_t;
  typedef logic [31:0]  be_t;

  // Replace the bytes of i_old whose enable bit is set.
  function automatic line_t merge_bytes(
    input line_t i_old,
    input line_t i_new,
    input be_t   i_be
  );
    line_t w_res;
    w_res = i_old;
    for (int b = 0; b < 32; b++) begin
      if (i_be[b]) begin
        w_res[b*8 +: 8] = i_new[b*8 +: 8];
      end
    end
    return w_res;
  endfunction

endpackage

// File: rtl/l2_line_array.sv
// Per-set storage: valid, dirty, tag and data flop arrays
// with one async read port and one field-enabled write port.
module l2_line_array
  import l2_types::*;
#(
  parameter int S_INDEX = DEF_S_INDEX,
  parameter int S_TAG   = DEF_S_TAG
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [S_INDEX-1:0] i_idx,
  output logic               o_valid,
  output logic               o_dirty,
  output logic [S_TAG-1:0]   o_tag,
  output line_t              o_data,
  input  logic               i_ld_valid,
  input  logic               i_valid,
  input  logic               i_ld_dirty,
  input  logic               i_dirty,
  input  logic               i_ld_tag,
  input  logic [S_TAG-1:0]   i_tag,
  input  logic               i_ld_data,
  input  line_t              i_data
);

  localparam int NSETS = 1 << S_INDEX;

  logic [NSETS-1:0] r_valid;
  logic [NSETS-1:0] r_dirty;
  logic [S_TAG-1:0] r_tag [NSETS];
  line_t            r_data [NSETS];

  // Status bits: reset invalidates every set, even one mid-fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_ld_valid) r_valid[i_idx] <= i_valid;
      if (i_ld_dirty) r_dirty[i_idx] <= i_dirty;
    end
  end

  // Tag and data payload: never reset, guarded by valid.
  always_ff @(posedge clk) begin
    if (i_ld_tag)  r_tag[i_idx]  <= i_tag;
    if (i_ld_data) r_data[i_idx] <= i_data;
  end

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];

endmodule

// File: rtl/l2_cache.sv
// Direct-mapped write-back L2: hit service, dirty-victim
// writeback and line fill, one request at a time.
module l2_cache
  import l2_types::*;
#(
  parameter int S_INDEX  = DEF_S_INDEX,
  parameter int S_OFFSET = DEF_S_OFFSET,
  parameter int S_TAG    = 32 - S_INDEX - S_OFFSET
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [31:0]   mem_address,
  input  logic [255:0]  mem_wdata256,
  input  logic [31:0]   mem_byte_enable256,
  output logic [255:0]  mem_rdata256,
  output logic          mem_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [31:0]   pmem_address,
  output logic [255:0]  pmem_wdata256,
  input  logic [255:0]  pmem_rdata256,
  input  logic          pmem_resp
);

  localparam int TAG_LSB = S_OFFSET + S_INDEX;

  state_e             r_state;
  state_e             w_next;
  logic [S_TAG-1:0]   r_tag;
  logic [S_INDEX-1:0] r_idx;
  line_t              r_wdata;
  be_t                r_be;
  logic               r_write;

  logic               w_valid;
  logic               w_dirty;
  logic [S_TAG-1:0]   w_tag;
  line_t              w_data;
  logic               w_hit;
  logic               w_req;

  logic               w_ld_valid;
  logic               w_ld_dirty;
  logic               w_dirty_in;
  logic               w_ld_tag;
  logic               w_ld_data;
  line_t              w_data_in;

  logic               w_unused_offset;

  assign w_unused_offset = ^mem_address[S_OFFSET-1:0];
  assign w_req = mem_read | mem_write;
  assign w_hit = w_valid && (w_tag == r_tag);

  l2_line_array #(
    .S_INDEX (S_INDEX),
    .S_TAG   (S_TAG)
  ) u_lines (
    .clk        (clk),
    .rst        (rst),
    .i_idx      (r_idx),
    .o_valid    (w_valid),
    .o_dirty    (w_dirty),
    .o_tag      (w_tag),
    .o_data     (w_data),
    .i_ld_valid (w_ld_valid),
    .i_valid    (1'b1),
    .i_ld_dirty (w_ld_dirty),
    .i_dirty    (w_dirty_in),
    .i_ld_tag   (w_ld_tag),
    .i_tag      (r_tag),
    .i_ld_data  (w_ld_data),
    .i_data     (w_data_in)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Capture the request; both strobes together mean write.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && w_req) begin
      r_tag   <= mem_address[TAG_LSB +: S_TAG];
      r_idx   <= mem_address[S_OFFSET +: S_INDEX];
      r_wdata <= mem_wdata256;
      r_be    <= mem_byte_enable256;
      r_write <= mem_write;
    end
  end

  // Next state, array write controls and outputs.
  always_comb begin
    w_next        = r_state;
    mem_resp      = 1'b0;
    mem_rdata256  = '0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_address  = '0;
    pmem_wdata256 = '0;
    w_ld_valid    = 1'b0;
    w_ld_dirty    = 1'b0;
    w_dirty_in    = 1'b0;
    w_ld_tag      = 1'b0;
    w_ld_data     = 1'b0;
    w_data_in     = pmem_rdata256;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req) w_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_hit) begin
          w_next = ST_DONE;
          if (r_write) begin
            w_ld_data  = 1'b1;
            w_data_in  =
              merge_bytes(w_data, r_wdata, r_be);
            w_ld_dirty = 1'b1;
            w_dirty_in = 1'b1;
          end
        end else if (w_valid && w_dirty) begin
          w_next = ST_WRITEBACK;
        end else begin
          w_next = ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_address  =
          {w_tag, r_idx, {S_OFFSET{1'b0}}};
        pmem_wdata256 = w_data;
        if (pmem_resp) w_next = ST_ALLOCATE;
      end
      ST_ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address =
          {r_tag, r_idx, {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          w_ld_data  = 1'b1;
          w_ld_tag   = 1'b1;
          w_ld_valid = 1'b1;
          w_ld_dirty = 1'b1;
          w_dirty_in = 1'b0;
          w_next     = ST_CHECK;
        end
      end
      ST_DONE: begin
        mem_resp     = 1'b1;
        mem_rdata256 = w_data;
        w_next       = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (rst) begin
      mem_resp      = 1'b0;
      mem_rdata256  = '0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_address  = '0;
      pmem_wdata256 = '0;
    end
  end

endmodule

// File: tb/tb_l2_cache.sv
// Scoreboard bench for l2_cache: directed requests against
// a 5-cycle physical memory model.
module tb_l2_cache;
  import l2_types::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_address = '0;
  line_t       mem_wdata256 = '0;
  be_t         mem_byte_enable256 = '0;
  line_t       mem_rdata256;
  logic        mem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  line_t       pmem_wdata256;
  line_t       pmem_rdata256 = '0;
  logic        pmem_resp = 1'b0;

  l2_cache dut (
    .clk                (clk),
    .rst                (rst),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .mem_address        (mem_address),
    .mem_wdata256       (mem_wdata256),
    .mem_byte_enable256 (mem_byte_enable256),
    .mem_rdata256       (mem_rdata256),
    .mem_resp           (mem_resp),
    .pmem_read          (pmem_read),
    .pmem_write         (pmem_write),
    .pmem_address       (pmem_address),
    .pmem_wdata256      (pmem_wdata256),
    .pmem_rdata256      (pmem_rdata256),
    .pmem_resp          (pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    line_t data;
    int    kind;
    int    t0;
  } resp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    line_t       data;
  } pm_t;

  resp_t rq[$];
  pm_t   pq[$];
  line_t mem [logic [31:0]];

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_resp_cyc = -100;
  int   cnt = 0;
  logic [1:0] prev_pm = 2'b00;
  logic prev_resp = 1'b0;

  line_t A, B, A_mod, B_mod, wd0, wd1;

  task automatic chk(input string name,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name,
                      input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d",
               name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Physical memory: respond 5 cycles into each request.
  always @(negedge clk) begin
    if (rst) begin
      cnt = 0;
      pmem_resp = 1'b0;
    end else if (pmem_resp) begin
      pmem_resp = 1'b0;
      cnt = (pmem_read || pmem_write) ? 1 : 0;
    end else if (!(pmem_read || pmem_write)) begin
      cnt = 0;
    end else begin
      cnt++;
      if (cnt == 5) begin
        pmem_resp = 1'b1;
        last_resp_cyc = cyc;
        if (pmem_write)
          mem[pmem_address] = pmem_wdata256;
        else if (mem.exists(pmem_address))
          pmem_rdata256 = mem[pmem_address];
        else
          pmem_rdata256 = '0;
      end
    end
  end

  // Monitor: upstream responses and pmem request starts.
  always @(negedge clk) begin
    resp_t e;
    pm_t   p;
    logic [1:0] cur;
    cur = {pmem_read, pmem_write};
    if (!rst) begin
      chki("pmem_excl", int'(pmem_read & pmem_write), 0);
      if (mem_resp) begin
        chki("resp_width", int'(prev_resp), 0);
        if (rq.size() == 0) begin
          chki("resp_unexpected", 1, 0);
        end else begin
          e = rq.pop_front();
          chk("rdata", mem_rdata256, e.data);
          if (e.kind == 0)
            chki("hit_lat", cyc - e.t0, 2);
          else
            chki("miss_lat", cyc - last_resp_cyc, 2);
        end
      end
      if (cur != 2'b00 && cur != prev_pm) begin
        if (pq.size() == 0) begin
          chk("pmem_unexpected", cur, 2'b00);
        end else begin
          p = pq.pop_front();
          chk("pmem_kind", cur, {~p.wr, p.wr});
          chk("pmem_addr", pmem_address, p.addr);
          if (p.wr)
            chk("pmem_wdata", pmem_wdata256, p.data);
          if (!p.wr && prev_pm == 2'b01)
            chki("fill_after_wb",
                 cyc - last_resp_cyc, 1);
        end
      end
    end
    prev_resp = mem_resp;
    prev_pm = rst ? 2'b00 : cur;
  end

  task automatic pm_exp(input logic wr,
                        input logic [31:0] a,
                        input line_t d);
    pm_t p;
    p.wr = wr;
    p.addr = a;
    p.data = d;
    pq.push_back(p);
  endtask

  task automatic req(input logic rd, input logic wr,
                     input logic [31:0] a,
                     input line_t wd, input be_t be,
                     input line_t exp, input int kind);
    resp_t e;
    int k;
    @(posedge clk);
    #1;
    mem_read = rd;
    mem_write = wr;
    mem_address = a;
    mem_wdata256 = wd;
    mem_byte_enable256 = be;
    e.data = exp;
    e.kind = kind;
    e.t0 = cyc;
    rq.push_back(e);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!mem_resp && k < 200);
    if (!mem_resp) begin
      chki("resp_timeout", k, 0);
      rq.delete();
    end
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    int k;
    for (int i = 0; i < 8; i++) begin
      A[i*32 +: 32] = 32'hAAAA_0000 + i;
      B[i*32 +: 32] = 32'hBBBB_0000 + i;
    end
    A_mod = A;
    A_mod[31:0] = 32'hDEADBEEF;
    B_mod = B;
    B_mod[63:32] = 32'h12345678;
    wd0 = {8{32'h55555555}};
    wd0[31:0] = 32'hDEADBEEF;
    wd1 = {8{32'h66666666}};
    wd1[63:32] = 32'h12345678;
    mem[32'h0000_1040] = A;
    mem[32'h0000_2040] = B;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_resp", mem_resp, 1'b0);
    chk("rst_pread", pmem_read, 1'b0);
    chk("rst_pwrite", pmem_write, 1'b0);
    chk("rst_paddr", pmem_address, 32'h0);
    chk("rst_rdata", mem_rdata256, 256'h0);
    chk("rst_pwdata", pmem_wdata256, 256'h0);

    pm_exp(1'b0, 32'h0000_1040, '0);
    req(1, 0, 32'h0000_1040, '0, '0, A, 1);
    req(1, 0, 32'h0000_1040, '0, '0, A, 0);
    req(0, 1, 32'h0000_1040, wd0, 32'h0000_000F,
        A_mod, 0);
    req(1, 0, 32'h0000_1040, '0, '0, A_mod, 0);

    pm_exp(1'b1, 32'h0000_1040, A_mod);
    pm_exp(1'b0, 32'h0000_2040, '0);
    req(1, 0, 32'h0000_2040, '0, '0, B, 1);

    pm_exp(1'b0, 32'h0000_1040, '0);
    @(posedge clk);
    #1;
    mem_read = 1'b1;
    mem_address = 32'h0000_1040;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!pmem_read && k < 50);
    chki("alloc_reached", int'(pmem_read), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_pread", pmem_read, 1'b0);
    chk("mid_rst_resp", mem_resp, 1'b0);
    chk("mid_rst_pwrite", pmem_write, 1'b0);

    pm_exp(1'b0, 32'h0000_2040, '0);
    req(1, 0, 32'h0000_2040, '0, '0, B, 1);
    req(1, 1, 32'h0000_2040, wd1, 32'h0000_00F0,
        B_mod, 0);

    pm_exp(1'b1, 32'h0000_2040, B_mod);
    pm_exp(1'b0, 32'h0000_1040, '0);
    req(1, 0, 32'h0000_1040, '0, '0, A_mod, 1);

    repeat (10) @(posedge clk);
    #1;
    chki("rq_drained", rq.size(), 0);
    chki("pq_drained", pq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
